// File: rtl/gen_clk_div.sv
// gen_clk_div: parametrised power-of-two clock divider with glitch-free
// start/stop, per-output rising-edge strobes and a boundary-switched select.
// Every output is registered from the next-state values.

// One divided output: registers its clock level and its rising-edge strobe.
module gen_clk_div_lane (
  input  logic clk_8f,
  input  logic rst,
  input  logic run_nxt,      // divider is active in the coming cycle
  input  logic cnt_bit_nxt,  // this lane's bit of the next count
  input  logic low_clr_nxt,  // every lower bit of the next count is zero
  output logic div_nxt,      // next level, used by the select mux
  output logic clk_div,
  output logic stb
);

  assign div_nxt = run_nxt & ~cnt_bit_nxt;

  // Register the level and the strobe that marks its rising edge.
  always_ff @(posedge clk_8f or posedge rst) begin
    if (rst) begin
      clk_div <= 1'b0;
      stb     <= 1'b0;
    end else begin
      clk_div <= div_nxt;
      stb     <= div_nxt & low_clr_nxt;
    end
  end

endmodule

module gen_clk_div #(
  parameter int CNT_W = 3,
  parameter int SEL_W = 2
) (
  input  logic             clk_8f,
  input  logic             rst,
  input  logic             enb,
  input  logic [SEL_W-1:0] div_sel,
  output logic [CNT_W-1:0] clk_div,
  output logic [CNT_W-1:0] stb,
  output logic             clk_sel,
  output logic [SEL_W-1:0] sel_cur,
  output logic             running
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SEL_W:0]   SEL_LIM = (SEL_W+1)'(CNT_W);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] div_nxt;
  logic [CNT_W-1:0] low_clr;
  logic             low_acc;
  logic             run_nxt;
  logic             sel_ld;
  logic [SEL_W-1:0] sel_nxt;
  logic             clk_sel_nxt;

  // State and master counter.
  always_ff @(posedge clk_8f or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: stopping is only allowed to land on the all-low last cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (enb) state_nxt = RUN;
      end
      RUN: begin
        if (!enb) state_nxt = STOPPING;
      end
      STOPPING: begin
        if (enb)                 state_nxt = RUN;
        else if (cnt == CNT_MAX) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Next outputs: strobe masks, select load on period boundaries, select mux.
  always_comb begin
    run_nxt = (state_nxt != IDLE);
    low_acc = 1'b1;
    low_clr = '0;
    for (int i = 0; i < CNT_W; i++) begin
      low_clr[i] = low_acc;
      low_acc    = low_acc & ~cnt_nxt[i];
    end
    // cnt_nxt is zero in IDLE, so this also covers the every-cycle IDLE load.
    sel_ld      = ({1'b0, div_sel} < SEL_LIM) && (cnt_nxt == '0);
    sel_nxt     = sel_ld ? div_sel : sel_cur;
    clk_sel_nxt = 1'b0;
    for (int i = 0; i < CNT_W; i++) begin
      if (sel_nxt == SEL_W'(i)) clk_sel_nxt = div_nxt[i];
    end
  end

  for (genvar i = 0; i < CNT_W; i++) begin : gen_lane
    gen_clk_div_lane u_lane (
      .clk_8f      (clk_8f),
      .rst         (rst),
      .run_nxt     (run_nxt),
      .cnt_bit_nxt (cnt_nxt[i]),
      .low_clr_nxt (low_clr[i]),
      .div_nxt     (div_nxt[i]),
      .clk_div     (clk_div[i]),
      .stb         (stb[i])
    );
  end

  // Shared output registers.
  always_ff @(posedge clk_8f or posedge rst) begin
    if (rst) begin
      sel_cur <= '0;
      clk_sel <= 1'b0;
      running <= 1'b0;
    end else begin
      sel_cur <= sel_nxt;
      clk_sel <= clk_sel_nxt;
      running <= run_nxt;
    end
  end

endmodule
